// File: rtl/vx_tex_fetch.sv
// vx_tex_fetch: issues word reads for per-lane texels, gathers tagged responses in any order, extracts texels.
// Build option TEX_FETCH_DEDUP_EN: bilinear texels sharing a word address within a lane reuse one read.
module vx_tex_fetch #(
    parameter int CORE_ID   = 0,
    parameter int NUM_REQS  = 4,
    parameter int REQ_INFOW = 1,
    parameter int BLEND_W   = 8,
    localparam int TAGW     = $clog2(NUM_REQS) + 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    input  logic [NUM_REQS-1:0]           req_tmask,
    input  logic                          req_filter,
    input  logic [1:0]                    req_lgstride,
    input  logic [NUM_REQS*32-1:0]        req_baseaddr,
    input  logic [NUM_REQS*4*32-1:0]      req_addr,
    input  logic [NUM_REQS*2*BLEND_W-1:0] req_blends,
    input  logic [REQ_INFOW-1:0]          req_info,
    output logic                          req_ready,
    output logic                          mem_req_valid,
    output logic [29:0]                   mem_req_addr,
    output logic [TAGW-1:0]               mem_req_tag,
    input  logic                          mem_req_ready,
    input  logic                          mem_rsp_valid,
    input  logic [31:0]                   mem_rsp_data,
    input  logic [TAGW-1:0]               mem_rsp_tag,
    output logic                          mem_rsp_ready,
    output logic                          rsp_valid,
    output logic [NUM_REQS-1:0]           rsp_tmask,
    output logic                          rsp_filter,
    output logic [NUM_REQS*2*BLEND_W-1:0] rsp_blends,
    output logic [REQ_INFOW-1:0]          rsp_info,
    output logic [NUM_REQS*4*32-1:0]      rsp_texels,
    input  logic                          rsp_ready
);
    localparam int NSLOT = NUM_REQS * 4;
    localparam int CNTW  = $clog2(NSLOT + 1);

    typedef enum logic [1:0] { IDLE, ISSUE, WAIT, DONE } state_t;
    state_t state_q, state_d;

    logic [NSLOT-1:0] pending_q, pending_d, pending_init;
    logic [NSLOT-1:0] issue_onehot, rsp_hit;
    logic [31:0]      addr_q    [NSLOT];
    logic [31:0]      addr_init [NSLOT];
    logic [1:0]       lgstride_q;
    logic [CNTW-1:0]  outstanding_q, outstanding_d;
    logic [TAGW-1:0]  issue_idx;
    logic             req_fire, issue_fire, rsp_fire;

    function automatic logic [31:0] extract(input logic [31:0] data, input logic [1:0] off,
                                            input logic [1:0] lgs);
        logic [31:0] w;
        w = data >> {off, 3'b000};
        case (lgs)
            2'd0:    return {24'd0, w[7:0]};
            2'd1:    return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    assign req_ready     = (state_q == IDLE);
    assign req_fire      = req_valid && req_ready;
    assign mem_req_valid = (state_q == ISSUE) && (pending_q != '0);
    assign issue_fire    = mem_req_valid && mem_req_ready;
    assign mem_rsp_ready = (state_q == ISSUE) || (state_q == WAIT);
    assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;
    assign rsp_valid     = (state_q == DONE);
    assign mem_req_addr  = addr_q[issue_idx][31:2];
    assign mem_req_tag   = issue_idx;

    always_comb begin
        for (int j = 0; j < NSLOT; j++) begin
            addr_init[j] = req_baseaddr[(j/4)*32 +: 32] + req_addr[j*32 +: 32];
        end
    end

`ifdef TEX_FETCH_DEDUP_EN
    logic [NSLOT-1:0] alias_q, alias_init;
    logic [1:0]       src_q    [NSLOT];
    logic [1:0]       src_init [NSLOT];

    // descending scan so the earliest matching texel of the lane becomes the source
    always_comb begin
        alias_init = '0;
        for (int j = 0; j < NSLOT; j++) src_init[j] = 2'd0;
        for (int l = 0; l < NUM_REQS; l++) begin
            for (int t = 1; t < 4; t++) begin
                for (int i = t - 1; i >= 0; i--) begin
                    if (req_filter && addr_init[l*4+t][31:2] == addr_init[l*4+i][31:2]) begin
                        alias_init[l*4+t] = 1'b1;
                        src_init[l*4+t]   = 2'(i);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alias_q <= '0;
            for (int j = 0; j < NSLOT; j++) src_q[j] <= 2'd0;
        end else if (req_fire) begin
            alias_q <= alias_init;
            src_q   <= src_init;
        end
    end

    always_comb begin
        for (int j = 0; j < NSLOT; j++) begin
            pending_init[j] = req_tmask[j/4] && (req_filter || (j % 4) == 0) && !alias_init[j];
            rsp_hit[j]      = (mem_rsp_tag == TAGW'(j)) ||
                              (alias_q[j] && mem_rsp_tag == (TAGW'((j / 4) * 4) | TAGW'(src_q[j])));
        end
    end
`else
    always_comb begin
        for (int j = 0; j < NSLOT; j++) begin
            pending_init[j] = req_tmask[j/4] && (req_filter || (j % 4) == 0);
            rsp_hit[j]      = (mem_rsp_tag == TAGW'(j));
        end
    end
`endif

    always_comb begin
        issue_idx = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (pending_q[i]) issue_idx = TAGW'(i);
        end
    end

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        outstanding_d = outstanding_q;
        issue_onehot  = '0;
        if (issue_fire) begin
            issue_onehot[issue_idx] = 1'b1;
            pending_d = pending_q & ~issue_onehot;
        end
        if (req_fire) pending_d = pending_init;
        if (issue_fire && !rsp_fire) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!issue_fire && rsp_fire && outstanding_q != '0) begin
            outstanding_d = outstanding_q - 1'b1;
        end
        case (state_q)
            IDLE:    if (req_valid) state_d = ISSUE;
            ISSUE:   if (pending_d == '0) state_d = (outstanding_d == '0) ? DONE : WAIT;
            WAIT:    if (outstanding_d == '0) state_d = DONE;
            DONE:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            pending_q     <= '0;
            outstanding_q <= '0;
            lgstride_q    <= '0;
            rsp_tmask     <= '0;
            rsp_filter    <= 1'b0;
            rsp_blends    <= '0;
            rsp_info      <= '0;
            rsp_texels    <= '0;
            for (int j = 0; j < NSLOT; j++) addr_q[j] <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            if (req_fire) begin
                lgstride_q <= req_lgstride;
                rsp_tmask  <= req_tmask;
                rsp_filter <= req_filter;
                rsp_blends <= req_blends;
                rsp_info   <= req_info;
                rsp_texels <= '0;
                addr_q     <= addr_init;
            end else if (rsp_fire) begin
                for (int j = 0; j < NSLOT; j++) begin
                    if (rsp_hit[j]) begin
                        rsp_texels[j*32 +: 32] <= extract(mem_rsp_data, addr_q[j][1:0], lgstride_q);
                    end
                end
            end
        end
    end

endmodule
